// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and select codes.
package mcu_pkg;

  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/mcu_decode.sv
// Pure combinational opcode decode into datapath selects and instruction class flags.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_imm_sel,
  output logic       o_a_sel,
  output logic       o_b_sel,
  output logic [3:0] o_alu_sel,
  output logic [1:0] o_wb_sel,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_is_jump,
  output logic       o_legal
);

  always_comb begin
    o_imm_sel   = IMM_R;
    o_a_sel     = 1'b0;
    o_b_sel     = 1'b0;
    o_alu_sel   = 4'b0000;
    o_wb_sel    = WB_MEM;
    o_is_load   = 1'b0;
    o_is_store  = 1'b0;
    o_is_branch = 1'b0;
    o_is_jump   = 1'b0;
    o_legal     = 1'b1;
    case (i_opcode)
      LW: begin
        o_b_sel   = 1'b1;
        o_imm_sel = IMM_I;
        o_is_load = 1'b1;
      end
      SW: begin
        o_b_sel    = 1'b1;
        o_imm_sel  = IMM_S;
        o_is_store = 1'b1;
      end
      OP_I: begin
        o_b_sel   = 1'b1;
        o_imm_sel = IMM_I;
        o_alu_sel = {1'b0, i_funct3};
        o_wb_sel  = WB_ALU;
      end
      OP: begin
        o_alu_sel = {i_funct7b5, i_funct3};
        o_wb_sel  = WB_ALU;
      end
      JAL: begin
        o_a_sel   = 1'b1;
        o_b_sel   = 1'b1;
        o_imm_sel = IMM_J;
        o_wb_sel  = WB_PC4;
        o_is_jump = 1'b1;
      end
      JALR: begin
        o_b_sel   = 1'b1;
        o_imm_sel = IMM_I;
        o_wb_sel  = WB_PC4;
        o_is_jump = 1'b1;
      end
      BRANCH: begin
        o_a_sel     = 1'b1;
        o_b_sel     = 1'b1;
        o_imm_sel   = IMM_B;
        o_is_branch = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control FSM with req/ready memory handshakes and illegal-opcode trap.
// Optional memory wait timeout trap enabled by defining MCU_MEM_TIMEOUT_EN.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ins,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            beq,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dm_we,
  output logic            RF_we,
  output logic            pc_we,
  output logic            pcsel,
  output logic            a_sel,
  output logic            b_sel,
  output logic [1:0]      wb_sel,
  output logic [2:0]      imm_sel,
  output logic [3:0]      alu_sel,
  output logic            illegal,
  output logic [2:0]      state_o
`ifdef MCU_MEM_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);

  state_t          r_state;
  logic [XLEN-1:0] r_ir;
  logic            r_illegal;

  logic [2:0] w_imm_sel;
  logic       w_a_sel;
  logic       w_b_sel;
  logic [3:0] w_alu_sel;
  logic [1:0] w_wb_sel;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;
  logic       w_is_jump;
  logic       w_legal;
  logic       w_timeout_hit;
  logic       w_unused_ir;

  mcu_decode u_decode (
    .i_opcode   (r_ir[6:0]),
    .i_funct3   (r_ir[14:12]),
    .i_funct7b5 (r_ir[30]),
    .o_imm_sel  (w_imm_sel),
    .o_a_sel    (w_a_sel),
    .o_b_sel    (w_b_sel),
    .o_alu_sel  (w_alu_sel),
    .o_wb_sel   (w_wb_sel),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store),
    .o_is_branch(w_is_branch),
    .o_is_jump  (w_is_jump),
    .o_legal    (w_legal)
  );

  assign w_unused_ir = ^{r_ir[XLEN-1:31], r_ir[29:15], r_ir[11:7]};

`ifdef MCU_MEM_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;
  logic              w_waiting;

  // Any cycle not spent waiting zeroes the count, so every FETCH/MEM visit starts fresh.
  assign w_waiting     = ((r_state == FETCH) && !imem_ready) || ((r_state == MEM) && !dmem_ready);
  assign w_timeout_hit = w_waiting && (r_wait == WAIT_LAST);
  assign timeout       = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wait <= w_waiting ? r_wait + 1'b1 : '0;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end
`else
  localparam int unused_mem_timeout = MEM_TIMEOUT;
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ready) begin
            r_ir    <= ins;
            r_state <= DECODE;
          end else if (w_timeout_hit) begin
            r_state   <= TRAP;
            r_illegal <= 1'b1;
          end
        end
        DECODE: begin
          if (w_legal) begin
            r_state <= EXEC;
          end else begin
            r_state   <= TRAP;
            r_illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (w_is_branch)                  r_state <= FETCH;
          else if (w_is_load || w_is_store) r_state <= MEM;
          else                              r_state <= WB;
        end
        MEM: begin
          if (dmem_ready) begin
            r_state <= w_is_load ? WB : FETCH;
          end else if (w_timeout_hit) begin
            r_state   <= TRAP;
            r_illegal <= 1'b1;
          end
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Outputs are gated by rst so an abort mid-access can never leak a strobe.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dm_we    = 1'b0;
    RF_we    = 1'b0;
    pc_we    = 1'b0;
    pcsel    = 1'b0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    wb_sel   = WB_MEM;
    imm_sel  = IMM_R;
    alu_sel  = 4'b0000;
    if (!rst) begin
      if (r_state == EXEC || r_state == MEM || r_state == WB) begin
        a_sel   = w_a_sel;
        b_sel   = w_b_sel;
        imm_sel = w_imm_sel;
        alu_sel = w_alu_sel;
      end
      case (r_state)
        FETCH: imem_req = 1'b1;
        EXEC: begin
          if (w_is_branch) begin
            pc_we = 1'b1;
            pcsel = r_ir[12] ? !beq : beq;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dm_we    = w_is_store;
          pc_we    = w_is_store && dmem_ready;
        end
        WB: begin
          RF_we  = 1'b1;
          pc_we  = 1'b1;
          pcsel  = w_is_jump;
          wb_sel = w_wb_sel;
        end
        default: ;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: per-cycle expectations built from instruction class and planned waits.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        imem_ready, dmem_ready, beq;
  logic        imem_req, dmem_req, dm_we, RF_we, pc_we, pcsel, a_sel, b_sel, illegal;
  logic [1:0]  wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic [3:0]  alu_sel;
`ifdef MCU_MEM_TIMEOUT_EN
  logic        timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ins(ins), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .beq(beq), .imem_req(imem_req), .dmem_req(dmem_req), .dm_we(dm_we), .RF_we(RF_we),
    .pc_we(pc_we), .pcsel(pcsel), .a_sel(a_sel), .b_sel(b_sel), .wb_sel(wb_sel),
    .imm_sel(imm_sel), .alu_sel(alu_sel), .illegal(illegal), .state_o(state_o)
`ifdef MCU_MEM_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        imr;
    logic        dmr;
    logic        beq;
    logic [31:0] exp;
    logic [31:0] mask;
  } cyc_t;

  cyc_t trace[$];

  function automatic logic [31:0] pack(input logic [2:0] st, input logic ireq, input logic dreq,
                                       input logic dwe, input logic rfwe, input logic pcwe,
                                       input logic pcs, input logic as, input logic bs,
                                       input logic [1:0] wb, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ill);
    return {9'd0, st, ireq, dreq, dwe, rfwe, pcwe, pcs, as, bs, wb, imm, alu, ill, 2'b00};
  endfunction

  localparam logic [31:0] M_CORE = {9'd0, 3'h7, 5'h1F, 3'h0, 2'h0, 3'h0, 4'h0, 1'b1, 2'b00};
  localparam logic [31:0] M_PCS  = {9'd0, 3'h0, 5'h00, 3'h4, 2'h0, 3'h0, 4'h0, 1'b0, 2'b00};
  localparam logic [31:0] M_SEL  = {9'd0, 3'h0, 5'h00, 3'h3, 2'h0, 3'h7, 4'hF, 1'b0, 2'b00};
  localparam logic [31:0] M_WB   = {9'd0, 3'h0, 5'h00, 3'h0, 2'h3, 3'h0, 4'h0, 1'b0, 2'b00};

  function automatic logic [31:0] observed();
    return pack(state_o, imem_req, dmem_req, dm_we, RF_we, pc_we, pcsel, a_sel, b_sel,
                wb_sel, imm_sel, alu_sel, illegal);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction given its fetch and data wait counts.
  task automatic build(input logic [31:0] instr, input int wi, input int wd, input logic bq,
                       output logic trapped);
    cyc_t c;
    logic [2:0] f3;
    logic ld, st, br, jmp, ok, a, b, pcs;
    logic [1:0] wb;
    logic [2:0] imm;
    logic [3:0] alu;
    f3 = instr[14:12];
    ld = 0; st = 0; br = 0; jmp = 0; ok = 1; a = 0; b = 1; wb = 2'b00; imm = 3'b001; alu = 4'b0000;
    case (instr[6:0])
      7'b0000011: ld = 1;
      7'b0100011: begin st = 1; imm = 3'b010; end
      7'b0010011: begin wb = 2'b01; alu = {1'b0, f3}; end
      7'b0110011: begin b = 0; imm = 3'b000; wb = 2'b01; alu = {instr[30], f3}; end
      7'b1101111: begin jmp = 1; a = 1; imm = 3'b100; wb = 2'b10; end
      7'b1100111: begin jmp = 1; wb = 2'b10; end
      7'b1100011: begin br = 1; a = 1; imm = 3'b011; end
      default:    ok = 0;
    endcase
    trapped = !ok;
    for (int k = 0; k <= wi; k++) begin
      c.ins  = (k == wi) ? instr : $urandom;
      c.imr  = (k == wi);
      c.dmr  = 1'($urandom_range(0, 1));
      c.beq  = 1'($urandom_range(0, 1));
      c.exp  = pack(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd0, 0);
      c.mask = M_CORE;
      trace.push_back(c);
    end
    c.ins  = $urandom;
    c.imr  = 1'($urandom_range(0, 1));
    c.dmr  = 1'($urandom_range(0, 1));
    c.exp  = pack(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd0, 0);
    trace.push_back(c);
    if (!ok) begin
      for (int k = 0; k < 3; k++) begin
        c.imr = 1'($urandom_range(0, 1));
        c.exp = pack(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 4'd0, 1);
        trace.push_back(c);
      end
      return;
    end
    pcs    = f3[0] ? !bq : bq;
    c.beq  = bq;
    c.imr  = 1'($urandom_range(0, 1));
    c.exp  = pack(3'd2, 0, 0, 0, 0, br, br & pcs, a, b, 2'd0, imm, alu, 0);
    c.mask = M_CORE | M_SEL | (br ? M_PCS : 32'd0);
    trace.push_back(c);
    if (br) return;
    if (ld || st) begin
      for (int k = 0; k <= wd; k++) begin
        c.dmr  = (k == wd);
        c.imr  = 1'($urandom_range(0, 1));
        c.beq  = 1'($urandom_range(0, 1));
        c.exp  = pack(3'd3, 0, 1, st, 0, st && (k == wd), 0, a, b, 2'd0, imm, alu, 0);
        c.mask = M_CORE | M_SEL | ((st && (k == wd)) ? M_PCS : 32'd0);
        trace.push_back(c);
      end
      if (st) return;
    end
    c.dmr  = 1'($urandom_range(0, 1));
    c.imr  = 1'($urandom_range(0, 1));
    c.exp  = pack(3'd4, 0, 0, 0, 1, 1, jmp, a, b, wb, imm, alu, 0);
    c.mask = M_CORE | M_SEL | M_WB | M_PCS;
    trace.push_back(c);
  endtask

  task automatic run(input int n, input string name);
    for (int i = 0; i < n && trace.size() > 0; i++) begin
      cyc_t c = trace.pop_front();
      @(negedge clk);
      ins = c.ins; imem_ready = c.imr; dmem_ready = c.dmr; beq = c.beq;
      #2;
      chk($sformatf("%s_c%0d", name, i), observed() & c.mask, c.exp & c.mask);
    end
    trace.delete();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #1 rst = 1; imem_ready = 1; dmem_ready = 1;
    #1 chk({name, "_async"}, observed() & M_CORE, 32'd0);
    @(negedge clk);
    #1 chk({name, "_hold"}, observed() & M_CORE, 32'd0);
    @(negedge clk);
    rst = 0; imem_ready = 0; dmem_ready = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  bad [6] = '{7'h7F, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h00};
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2: r[6:0] = 7'b0010011;
      3: r[6:0] = 7'b0110011;
      4: r[6:0] = 7'b1101111;
      5: r[6:0] = 7'b1100111;
      6: r[6:0] = 7'b1100011;
      default: r[6:0] = bad[$urandom_range(0, 5)];
    endcase
    return r;
  endfunction

  initial begin
    logic trapped;
    logic [31:0] instr;
    rst = 1; ins = '0; imem_ready = 0; dmem_ready = 0; beq = 0;
    #1 chk("reset_state", observed() & M_CORE, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;

    build(32'h002081B3, 0, 0, 1'b0, trapped); run(100, "add");
    build(32'h402081B3, 3, 0, 1'b0, trapped); run(100, "sub");
    build(32'h0000A183, 0, 2, 1'b0, trapped); run(100, "lw");
    build(32'h0030A023, 1, 1, 1'b0, trapped); run(100, "sw");
    build(32'h00209063, 0, 0, 1'b0, trapped); run(100, "bne_ne");
    build(32'h00209063, 0, 0, 1'b1, trapped); run(100, "bne_eq");
    build(32'h0000007F, 0, 0, 1'b0, trapped); run(100, "illegal");
    do_reset("ill_rst");

    // Abort in the middle of a data access: fetch, decode, exec and two MEM wait cycles.
    build(32'h0000A183, 0, 6, 1'b0, trapped); run(5, "lw_abort");
    do_reset("mem_rst");
    build(32'h0030A023, 0, 0, 1'b0, trapped); run(100, "after_abort");

`ifdef MCU_MEM_TIMEOUT_EN
    build(32'h0000A183, 0, 40, 1'b0, trapped); run(3, "lw_to");
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); dmem_ready = 0;
      #2 chk($sformatf("to_wait%0d", k), {29'd0, state_o, timeout}, {29'd0, 3'd3, 1'b0});
    end
    @(negedge clk);
    #2 chk("to_trap", {29'd0, state_o, timeout}, {29'd0, 3'd5, 1'b1});
    chk("to_illegal", {31'd0, illegal}, 32'd1);
    do_reset("to_rst");
    chk("to_clear", {31'd0, timeout}, 32'd0);
`endif

    for (int n = 0; n < 80; n++) begin
      instr = rand_instr();
      build(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), trapped);
      run(100, $sformatf("r%0d", n));
      if (trapped) do_reset($sformatf("r%0d_rst", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-stage combinational control unit.
- Sequences each RV32I-subset instruction (LW, SW, OP-IMM, OP, JAL, JALR, BRANCH) through FETCH/DECODE/EXEC/MEM/WB states.
- Talks to instruction and data memory over a req/ready handshake, so memory can have variable latency.
- Keeps its own instruction register and drives the datapath select/enable strobes, using the same encodings as the single-stage unit.
- Traps on illegal opcodes instead of emitting X.

Parameters:
XLEN, 32, instruction/datapath width; decode uses bits [6:0], [14:12], [30] only; must be >= 32.
MEM_TIMEOUT, 16, cycles to wait for ready before memory-timeout trap (used only with MCU_MEM_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ins  in  XLEN  instruction word from imem, valid when imem_ready=1
imem_ready  in  1  imem response handshake
dmem_ready  in  1  dmem access complete
beq  in  1  datapath comparator: rs1==rs2
imem_req  out  1  fetch request, held until imem_ready
dmem_req  out  1  data access request, held until dmem_ready
dm_we  out  1  store enable, valid with dmem_req
RF_we  out  1  register-file write strobe, 1 cycle
pc_we  out  1  PC update strobe, exactly one cycle per retired instruction
pcsel  out  1  0 = PC+4, 1 = ALU target
a_sel  out  1  0 = rs1, 1 = PC
b_sel  out  1  0 = rs2, 1 = immediate
wb_sel  out  2  00 mem, 01 ALU, 10 PC+4
imm_sel  out  3  000 R, 001 I, 010 S, 011 B, 100 J
alu_sel  out  4  ALU operation
illegal  out  1  sticky trap flag
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (async): state=FETCH; ir_q=0; illegal=0. All strobes are 0 while rst is high.
- Outputs are Moore: decoded from state and ir_q. No strobe may be X in any state.

FETCH:
- imem_req=1.
- On imem_ready: ir_q<=ins, go to DECODE. Otherwise stay in FETCH.

DECODE: one cycle, all strobes 0.
- Opcode not in the supported set -> TRAP.
- Otherwise -> EXEC.

EXEC: selects are driven as follows; a_sel/b_sel/imm_sel/alu_sel stay stable through MEM and WB.
- LW/SW: a=0, b=1, imm 001 (LW) or 010 (SW), alu 0000; -> MEM.
- OP-IMM: a=0, b=1, imm 001, alu={0,funct3}; -> WB.
- OP: a=0, b=0, imm 000, alu={ins[30],funct3}; -> WB.
- JAL: a=1, b=1, imm 100, alu 0000; -> WB.
- JALR: a=0, b=1, imm 001, alu 0000; -> WB.
- BRANCH: a=1, b=1, imm 011, alu 0000. pcsel = funct3[0] ? !beq : beq. pc_we=1, RF_we=0 (corrects the single-stage unit, which wrote RF on branches); -> FETCH.

MEM:
- dmem_req=1; dm_we=1 for SW only.
- On dmem_ready: LW -> WB; SW -> pc_we=1, pcsel=0, -> FETCH.

WB:
- RF_we=1 and pc_we=1 for one cycle; -> FETCH.
- wb_sel: LW 00, OP/OP-IMM 01, JAL/JALR 10.
- pcsel: 1 for JAL/JALR, else 0.

TRAP:
- illegal=1, all strobes 0. Stays until rst.

Latency with zero-wait memory (ready in the same cycle as req):
- OP/OP-IMM/JAL/JALR: 4 cycles.
- BRANCH: 3 cycles.
- SW: 4 cycles.
- LW: 5 cycles.
- Each wait cycle adds one.

Boundary cases:
- req stays high while waiting and only drops after the ready cycle.
- ready arriving in a state that did not request it is ignored.
- rst asserted mid-access: abort immediately to FETCH, with no pc_we/RF_we pulse.

Optional Feature:
- Macro: MCU_MEM_TIMEOUT_EN.
- Defined: a wait counter (width $clog2(MEM_TIMEOUT+1)) is cleared on entry to FETCH/MEM and increments each cycle req=1 && ready=0. When the count reaches MEM_TIMEOUT -> TRAP and illegal=1. Output timeout (1 bit, sticky) distinguishes this from an illegal opcode.
- Undefined: no counter, no timeout port; waits forever.

Decomposition:
- Package mcu_pkg: opcode localparams (LW, SW, OP_I, OP, JAL, JALR, BRANCH); state encoding; imm_sel/wb_sel encodings.
- One natural sub-module: mcu_decode, a pure combinational opcode -> {imm_sel, a_sel, b_sel, alu_sel, wb_sel, is_load, is_store, is_branch, is_jump, legal}. The FSM stays in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), zero-wait -> states 0,1,2,4; WB: RF_we=1, wb_sel=01, alu_sel=0000, pc_we=1, pcsel=0.
- SUB (0x402081B3), imem_ready delayed 3 cycles -> imem_req held 4 cycles; alu_sel=1000; total 7 cycles.
- LW 0x0000A183 with dmem_ready after 2 waits -> dmem_req held 3 cycles, dm_we=0; WB: wb_sel=00, imm_sel=001.
- SW 0x0030A023 -> MEM: dm_we=1; RF_we never 1; pc_we on the dmem_ready cycle.
- BNE (funct3=001) with beq=0 -> pcsel=1, pc_we=1 in EXEC; with beq=1 -> pcsel=0; RF_we=0 in both cases.
- Opcode 0x0000007F -> TRAP after DECODE, illegal=1 held. rst mid-MEM -> FETCH, no strobes. With MCU_MEM_TIMEOUT_EN, no dmem_ready -> timeout=1 after 16 cycles.
